// File: rtl/knn_if.sv
// Memory-read and sorter-control bundle between knn_ctrl (master) and
// the training memory plus distance/insertion sorter (slave).
interface knn_if #(
  parameter int unsigned W      = 32,
  parameter int unsigned ADDR_W = 8
);
  logic                     mem_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic [W-1:0]             mem_rdata;
  logic                     mem_rvalid;

  logic                     srt_rst;
  logic                     srt_valid;
  logic                     srt_done;
  logic [1:0]               srt_sel;
  logic signed [W/2-1:0]    srt_x1;
  logic signed [W/2-1:0]    srt_y1;
  logic signed [W/2-1:0]    srt_x2;
  logic signed [W/2-1:0]    srt_y2;
  logic [W/4-1:0]           srt_idx;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_rvalid,
    output srt_rst, srt_valid, srt_done, srt_sel,
    output srt_x1, srt_y1, srt_x2, srt_y2,
    input  srt_idx
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_rvalid,
    input  srt_rst, srt_valid, srt_done, srt_sel,
    input  srt_x1, srt_y1, srt_x2, srt_y2,
    output srt_idx
  );
endinterface

// File: rtl/knn_ctrl.sv
// k-NN query sequencer: clears the sorter, streams training points from memory
// in address order, then reads back the four nearest indices.
module knn_ctrl #(
  parameter int unsigned W      = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     n_train,
  input  logic signed [W/2-1:0] test_x,
  input  logic signed [W/2-1:0] test_y,
  knn_if.master                 bus,
  output logic                  busy,
  output logic                  done,
  output logic [W/4-1:0]        nn0,
  output logic [W/4-1:0]        nn1,
  output logic [W/4-1:0]        nn2,
  output logic [W/4-1:0]        nn3,
  output logic [2:0]            nn_cnt
);
  localparam int unsigned HW = W / 2;
  localparam int unsigned QW = W / 4;
  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_FEED0, S_FEED1, S_READOUT, S_DONE
  } state_t;

  state_t               state;
  logic [ADDR_W-1:0]    n_reg;
  logic [ADDR_W-1:0]    p;
  logic signed [HW-1:0] tx;
  logic signed [HW-1:0] ty;
  logic [QW-1:0]        rk0;
  logic [QW-1:0]        rk1;
  logic [QW-1:0]        rk2;
  logic                 last_pt_c;
  logic [2:0]           cnt_c;

  assign bus.srt_x1 = tx;
  assign bus.srt_y1 = ty;

  // compare one bit wider so a full-range n_train never wraps
  assign last_pt_c = (CW'(p) + CW'(1)) == CW'(n_reg);
  assign cnt_c     = (n_reg > ADDR_W'(3)) ? 3'd4 : 3'(n_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      n_reg         <= '0;
      p             <= '0;
      tx            <= '0;
      ty            <= '0;
      bus.srt_x2    <= '0;
      bus.srt_y2    <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.srt_rst   <= 1'b0;
      bus.srt_valid <= 1'b0;
      bus.srt_done  <= 1'b1;
      bus.srt_sel   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rk0           <= '0;
      rk1           <= '0;
      rk2           <= '0;
      nn0           <= '0;
      nn1           <= '0;
      nn2           <= '0;
      nn3           <= '0;
      nn_cnt        <= '0;
    end else begin
      bus.mem_req <= 1'b0;
      bus.srt_rst <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_reg        <= n_train;
            tx           <= test_x;
            ty           <= test_y;
            p            <= '0;
            busy         <= 1'b1;
            bus.srt_rst  <= 1'b1;
            bus.srt_done <= 1'b1;
            state        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          bus.srt_sel <= '0;
          if (n_reg == '0) begin
            state <= S_READOUT;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= p;
            state        <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            bus.srt_x2    <= bus.mem_rdata[W-1:HW];
            bus.srt_y2    <= bus.mem_rdata[HW-1:0];
            bus.srt_valid <= 1'b1;
            bus.srt_done  <= 1'b0;
            state         <= S_FEED0;
          end
        end
        S_FEED0: state <= S_FEED1;
        S_FEED1: begin
          p             <= p + ADDR_W'(1);
          bus.srt_valid <= 1'b0;
          bus.srt_done  <= 1'b1;
          if (last_pt_c) begin
            bus.srt_sel <= '0;
            state       <= S_READOUT;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= p + ADDR_W'(1);
            state        <= S_FETCH;
          end
        end
        S_READOUT: begin
          // srt_sel doubles as the rank counter and wraps back to 0 on exit
          unique case (bus.srt_sel)
            2'd0: rk0 <= bus.srt_idx;
            2'd1: rk1 <= bus.srt_idx;
            2'd2: rk2 <= bus.srt_idx;
            default: begin
              nn0    <= rk0;
              nn1    <= rk1;
              nn2    <= rk2;
              nn3    <= bus.srt_idx;
              nn_cnt <= cnt_c;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          endcase
          bus.srt_sel <= bus.srt_sel + 2'd1;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_knn_ctrl.sv
// Scoreboard bench for knn_ctrl with a behavioural training memory and a
// 4-deep squared-distance insertion sorter as the environment.
module tb_knn_ctrl;
  localparam int unsigned W      = 32;
  localparam int unsigned ADDR_W = 8;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     n_train;
  logic signed [W/2-1:0] test_x;
  logic signed [W/2-1:0] test_y;
  logic                  busy;
  logic                  done;
  logic [W/4-1:0]        nn0, nn1, nn2, nn3;
  logic [2:0]            nn_cnt;

  knn_if #(.W(W), .ADDR_W(ADDR_W)) bus ();

  knn_ctrl #(.W(W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_train(n_train),
    .test_x(test_x), .test_y(test_y), .bus(bus),
    .busy(busy), .done(done),
    .nn0(nn0), .nn1(nn1), .nn2(nn2), .nn3(nn3), .nn_cnt(nn_cnt)
  );

  typedef struct {
    int nn0; int nn1; int nn2; int nn3;
    int cnt; int n; int lat; int t0; int tx; int ty;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_fix = 1;
  logic [31:0] mem [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sorter model: list ascending by squared distance, ties keep the earlier point.
  longint    sd [4];
  logic [7:0] si [4];
  int        pidx;
  bit        half;
  longint    dd;
  longint    ddx;
  longint    ddy;
  int        pos;

  always @(posedge clk) begin
    if (bus.srt_rst) begin
      for (int i = 0; i < 4; i++) begin
        sd[i] = 64'sh7fff_ffff_ffff_ffff;
        si[i] = 8'd0;
      end
      pidx = 0;
      half = 1'b0;
    end else if (bus.srt_valid) begin
      if (half) begin
        ddx = longint'(bus.srt_x2) - longint'(bus.srt_x1);
        ddy = longint'(bus.srt_y2) - longint'(bus.srt_y1);
        dd  = ddx * ddx + ddy * ddy;
        pos = 4;
        for (int i = 3; i >= 0; i--) if (dd < sd[i]) pos = i;
        for (int i = 3; i > 0; i--) begin
          if (i > pos) begin
            sd[i] = sd[i-1];
            si[i] = si[i-1];
          end
        end
        if (pos < 4) begin
          sd[pos] = dd;
          si[pos] = 8'(pidx);
        end
        pidx = pidx + 1;
      end
      half = ~half;
    end else begin
      half = 1'b0;
    end
  end

  assign bus.srt_idx = si[bus.srt_sel];

  // Memory responder: rvalid arrives lat cycles after the request cycle.
  int         rl;
  logic [7:0] ra;
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        ra = bus.mem_addr;
        rl = (lat_fix == 0) ? int'($urandom_range(1, 5)) : lat_fix;
        repeat (rl) @(posedge clk);
        #1;
        bus.mem_rdata  = mem[ra];
        bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: per-cycle protocol checks and scoreboard pop on done.
  int   cnt_req = 0;
  int   cnt_val = 0;
  int   cnt_rst = 0;
  int   vrun = 0;
  bit   req_prev = 1'b0;
  bit   busy_after = 1'b0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt_req = 0; cnt_val = 0; cnt_rst = 0; vrun = 0;
        req_prev = 1'b0; busy_after = 1'b0;
        continue;
      end
      check("srt_done_vs_valid", bus.srt_done, !bus.srt_valid);
      if (bus.srt_valid) begin
        vrun++;
        cnt_val++;
      end else if (vrun != 0) begin
        check("valid_pair_len", vrun, 2);
        vrun = 0;
      end
      if (bus.mem_req) begin
        check("mem_req_one_cycle", req_prev, 0);
        check("mem_addr_order", bus.mem_addr, cnt_req);
        cnt_req++;
      end
      req_prev = bus.mem_req;
      if (bus.srt_rst) cnt_rst++;
      if (busy_after) begin
        check("busy_after_done", busy, 0);
        busy_after = 1'b0;
      end
      if (done) begin
        check("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("nn0", nn0, e.nn0);
          check("nn1", nn1, e.nn1);
          check("nn2", nn2, e.nn2);
          check("nn3", nn3, e.nn3);
          check("nn_cnt", nn_cnt, e.cnt);
          check("busy_in_done", busy, 1);
          check("mem_req_count", cnt_req, e.n);
          check("srt_valid_cycles", cnt_val, 2 * e.n);
          check("srt_rst_pulses", cnt_rst, 1);
          check("srt_x1", bus.srt_x1, e.tx);
          check("srt_y1", bus.srt_y1, e.ty);
          if (e.lat >= 0) check("done_latency", cyc - e.t0, e.lat);
        end
        cnt_req = 0; cnt_val = 0; cnt_rst = 0;
        busy_after = 1'b1;
      end
    end
  end

  task automatic load(input int idx, input int x, input int y);
    mem[idx] = {x[15:0], y[15:0]};
  endtask

  task automatic run(input int n, input int x, input int y,
                     input int e0, input int e1, input int e2, input int e3,
                     input int ec, input int lat, input bit push, input bit hold);
    exp_t t;
    @(posedge clk); #1;
    n_train = 8'(n);
    test_x  = 16'(x);
    test_y  = 16'(y);
    start   = 1'b1;
    if (push) begin
      t = '{nn0: e0, nn1: e1, nn2: e2, nn3: e3, cnt: ec, n: n,
            lat: lat, t0: cyc, tx: x, ty: y};
      sb.push_back(t);
    end
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    check("done_within_budget", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_zero_outputs"},
          longint'({busy, done, bus.mem_req, bus.mem_addr, bus.srt_rst, bus.srt_valid,
                    bus.srt_sel, nn0, nn1, nn2, nn3, nn_cnt}), 0);
    check({tag, "_zero_points"},
          longint'({bus.srt_x1, bus.srt_y1, bus.srt_x2, bus.srt_y2}), 0);
    check({tag, "_srt_done"}, bus.srt_done, 1);
  endtask

  task automatic load_set1();
    load(0, 10, 0); load(1, 1, 1); load(2, -3, 0); load(3, 0, 2); load(4, 5, 5);
  endtask

  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; n_train = '0; test_x = '0; test_y = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");

    load_set1();
    lat_fix = 1;
    run(5, 0, 0, 1, 3, 2, 4, 4, 26, 1'b1, 1'b0);
    wait_done(200);

    run(0, 5, -5, 0, 0, 0, 0, 0, 6, 1'b1, 1'b0);
    wait_done(50);

    load(0, 3, 4); load(1, 1, 0);
    lat_fix = 0;
    run(2, 0, 0, 1, 0, 0, 0, 2, -1, 1'b1, 1'b0);
    wait_done(100);

    load(0, 100, 100); load(1, -99, -99);
    lat_fix = 3;
    run(2, -100, -100, 1, 0, 0, 0, 2, 18, 1'b1, 1'b0);
    wait_done(100);

    // start held high for the whole run
    load(0, 0, 5); load(1, 2, 0); load(2, 1, 1);
    lat_fix = 2;
    run(3, 0, 0, 2, 1, 0, 0, 3, 21, 1'b1, 1'b1);
    wait_done(200);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("idle_after_held_start", busy, 0);

    load(0, 3, 4); load(1, 1, 0);
    lat_fix = 0;
    run(2, 0, 0, 1, 0, 0, 0, 2, -1, 1'b1, 1'b0);
    wait_done(100);

    // abort while waiting on point 2
    load_set1();
    lat_fix = 5;
    run(5, 0, 0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.mem_req && bus.mem_addr == 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_point2", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset("abort");
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_mem_req", cnt_req, 0);
    check("abort_idle", busy, 0);

    lat_fix = 1;
    run(5, 0, 0, 1, 3, 2, 4, 4, 26, 1'b1, 1'b0);
    wait_done(200);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
- Sequencer for the k-NN distance/insertion sorter (4-deep nearest list, 2-bit rank select, per-point index counter).
- On `start`, latches one test point and a training-set size, then clears the sorter.
- Fetches training points from a word memory in address order and feeds each point to the sorter.
- Freezes the sorter, reads ranks 0..3 into result registers, then pulses `done`.

Parameters:
W, 32, sorter word width; a point word packs X in [W-1:W/2] and Y in [W/2-1:0], both signed W/2 bits.
ADDR_W, 8, training memory address width; at most 2^ADDR_W-1 points per run.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request; sampled only in IDLE
n_train  in  ADDR_W  number of training points, latched at start
test_x  in  W/2  test point X (signed), latched at start
test_y  in  W/2  test point Y (signed), latched at start
mem_req  out  1  one-cycle read request
mem_addr  out  ADDR_W  read address, valid while mem_req=1
mem_rdata  in  W  read data {X,Y}
mem_rvalid  in  1  read data valid, at least 1 cycle after mem_req
srt_rst  out  1  sorter clear
srt_valid  out  1  sorter point strobe
srt_done  out  1  sorter freeze
srt_sel  out  2  sorter rank select
srt_x1, srt_y1  out  W/2 each  test point to sorter
srt_x2, srt_y2  out  W/2 each  training point to sorter
srt_idx  in  W/4  sorter index at rank srt_sel (combinational)
busy  out  1  run in progress
done  out  1  one-cycle run-complete pulse
nn0, nn1, nn2, nn3  out  W/4 each  indices of nearest..4th nearest
nn_cnt  out  3  number of meaningful nn entries = min(n_train,4)

Behaviour:
- Reset (synchronous): state=IDLE.
  - Zero: busy, done, mem_req, mem_addr, srt_rst, srt_valid, srt_sel, nn0..nn3, nn_cnt, point registers.
  - srt_done=1.
  - Reset mid-run aborts immediately; no further memory requests are issued. Pending mem_rvalid is ignored.
- FSM states and transitions:
  - IDLE:
    - start=1 -> latch n_train/test_x/test_y, point counter p=0, go CLEAR.
    - start=1 while busy is never seen (start is only sampled in IDLE, so it is ignored otherwise).
  - CLEAR (1 cycle): srt_rst=1, srt_done=1.
    - n_train==0 -> READOUT.
    - otherwise -> FETCH.
  - FETCH (1 cycle): mem_req=1, mem_addr=p -> WAIT.
  - WAIT: hold until mem_rvalid=1, then capture X/Y into srt_x2/srt_y2 -> FEED0. There is no timeout.
  - FEED0, FEED1 (1 cycle each): srt_valid=1 and srt_done=0 in both; the point is held stable across both cycles.
    - After FEED1: p=p+1.
    - If p+1==n_train -> READOUT, else FETCH.
  - READOUT (4 cycles, r=0..3): srt_done=1, srt_sel=r; capture srt_idx into nn[r] at the end of the cycle.
    - After r=3 -> DONE.
  - DONE (1 cycle): done=1, nn_cnt=min(n_train,4) -> IDLE.
- Output rules:
  - srt_done=1 in every state except FEED0/FEED1. srt_valid=1 only in FEED0/FEED1.
  - srt_x1/srt_y1 drive the latched test point continuously.
- Sorter index alignment: addresses are issued 0,1,2,… and each point is fed exactly once, so the sorter index equals the memory address of that point.
- Timing:
  - busy=1 from the cycle after start is sampled through the DONE cycle inclusive.
  - nn0..nn3/nn_cnt update only when DONE is entered, and hold until the next DONE.
  - With rvalid latency L, a run of n>0 points: done asserts 4n+6+n(L-1) cycles after the start sample cycle. n=0: done at cycle 6.
- Boundary cases:
  - n_train<4: nn entries at ranks ≥ n_train hold the sorter's cleared index (0). nn_cnt marks how many are meaningful.
  - n_train=2^ADDR_W-1: p counts to n_train-1, with no wrap.
  - mem_rvalid outside WAIT is ignored.
  - start coincident with rst: rst wins.

Test Plan:
- test=(0,0), n_train=5, mem[0..4]={(10,0),(1,1),(-3,0),(0,2),(5,5)}, L=1 -> nn0..3=1,3,2,4, nn_cnt=4, done 26 cycles after start.
- n_train=0 -> one srt_rst pulse, no mem_req, done 6 cycles after start, nn_cnt=0, nn0..3=0.
- n_train=2, mem={(3,4),(1,0)}, test=(0,0), random L in 1..5 -> nn0=1, nn1=0, nn_cnt=2; srt_valid high exactly 4 cycles, always in pairs.
- Negative coordinates: test=(-100,-100), mem[0]=(100,100), mem[1]=(-99,-99), n_train=2 -> nn0=1.
- start pulsed every cycle during a run -> exactly one run, one done pulse; a second start in IDLE after done begins a new run with srt_rst.
- rst asserted in WAIT of point 2 -> next cycle all outputs at reset values, srt_done=1, no further mem_req; a fresh start completes normally.
